// File: rtl/jtag_reg_ctrl.sv
// Debug-port register access controller: arbitrates JTAG reads/writes into the GPR file
// behind the core write-back port. Optional write read-back check: JTAG_WRITE_VERIFY_EN.
module jtag_reg_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  input  logic        core_w_enable_i,
  output logic        jtag_w_enable_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_w_data_o,
  input  logic [31:0] jtag_r_data_i
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] RETRY_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
`ifdef JTAG_WRITE_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t          state_q, state_n;
  logic [RW-1:0]   retry_q, retry_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic [DW-1:0]   rdata_q, rdata_n;
  logic            err_q, err_n;
  logic            ready_q, ready_n;
  logic            valid_q, valid_n;
  logic            wen_q, wen_n;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      retry_q <= retry_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      wen_q   <= wen_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n = state_q;
    retry_n = retry_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    err_n   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          addr_n  = req_addr_i;
          wdata_n = req_wdata_i;
          retry_n = '0;
          if (!req_write_i) begin
            state_n = S_READ;
          end else if (req_addr_i == '0) begin
            // x0 is hardwired: acknowledge without touching the register file
            state_n = S_RESP;
            rdata_n = req_wdata_i;
            err_n   = 1'b0;
          end else begin
            state_n = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (!core_w_enable_i) begin
`ifdef JTAG_WRITE_VERIFY_EN
          state_n = S_VERIFY;
`else
          state_n = S_RESP;
          rdata_n = wdata_q;
          err_n   = 1'b0;
`endif
        end else if (retry_q == RETRY_LAST) begin
          // Core port kept the file busy for the whole retry window
          state_n = S_RESP;
          rdata_n = wdata_q;
          err_n   = 1'b1;
          retry_n = retry_q + RW'(1);
        end else begin
          retry_n = retry_q + RW'(1);
        end
      end

      S_READ: begin
        state_n = S_RESP;
        rdata_n = (addr_q == '0) ? '0 : jtag_r_data_i;
        err_n   = 1'b0;
      end

`ifdef JTAG_WRITE_VERIFY_EN
      S_VERIFY: begin
        state_n = S_RESP;
        rdata_n = jtag_r_data_i;
        err_n   = (jtag_r_data_i != wdata_q);
      end
`endif

      S_RESP: begin
        if (resp_ready_i) begin
          state_n = S_IDLE;
          retry_n = '0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    ready_n = (state_n == S_IDLE);
    valid_n = (state_n == S_RESP);
    wen_n   = (state_n == S_WRITE);
  end

  assign req_ready_o     = ready_q;
  assign resp_valid_o    = valid_q;
  assign resp_rdata_o    = rdata_q;
  assign resp_err_o      = err_q;
  assign jtag_w_enable_o = wen_q;
  assign jtag_addr_o     = addr_q;
  assign jtag_w_data_o   = wdata_q;

endmodule

// File: tb/tb_jtag_reg_ctrl.sv
// Self-checking bench for jtag_reg_ctrl: transaction-level model of the register file
// and response timing, a per-cycle compare process, and literal anchors for key cases.
module tb_jtag_reg_ctrl;

`ifdef JTAG_WRITE_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        core_w_en = 1'b0;
  logic        jtag_wen;
  logic [4:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf  [32];
  logic [31:0] mrf [32];

  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  logic [31:0] got_rdata;
  logic        got_err;

  jtag_reg_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_rdata_o    (resp_rdata),
    .resp_err_o      (resp_err),
    .core_w_enable_i (core_w_en),
    .jtag_w_enable_o (jtag_wen),
    .jtag_addr_o     (jtag_addr),
    .jtag_w_data_o   (jtag_wdata),
    .jtag_r_data_i   (jtag_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hBAD0_0BAD;
    if (i == 2) return 32'h0000_1000;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Register file: core port has priority; x0 deliberately holds junk so the DUT must mask it
  initial for (int i = 0; i < 32; i++) rf[i] = init_val(i);
  always @(posedge clk) if (jtag_wen && !core_w_en) rf[jtag_addr] <= jtag_wdata;
  assign jtag_rdata = rf[jtag_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expected response
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        chk("resp_expected", 32'(resp_valid), 32'(exp_valid));
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        chk("wen_in_resp", 32'(jtag_wen), 32'd0);
        chk("addr_in_resp", 32'(jtag_addr), 32'(exp_addr));
      end
      if (jtag_wen) begin
        chk("wen_addr", 32'(jtag_addr), 32'(exp_addr));
        chk("wen_data", jtag_wdata, exp_wdata);
        chk("wen_x0", 32'(jtag_addr == 5'd0), 32'd0);
        chk("ready_in_write", 32'(req_ready), 32'd0);
      end
    end
  end

  // One command end to end; blocked = cycles the core port keeps the file busy
  task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input int blocked, input int hold);
    int cyc;
    int lat;
    int wen_cnt;
    int exp_lat;
    int exp_wen;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_before_cmd", 32'(req_ready), 32'd1);

    exp_addr  = a;
    exp_wdata = d;
    exp_err   = 1'b0;
    if (!wr) begin
      exp_rdata = (a == 5'd0) ? 32'h0 : mrf[a];
      exp_lat = 2; exp_wen = 0;
    end else if (a == 5'd0) begin
      exp_rdata = d; exp_lat = 1; exp_wen = 0;
    end else if (blocked >= 16) begin
      exp_rdata = d; exp_err = 1'b1; exp_lat = 17; exp_wen = 16;
    end else begin
      exp_rdata = d; exp_lat = blocked + 2 + VER; exp_wen = blocked + 1;
      mrf[a] = d;
    end
    exp_valid = 1'b1;

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    core_w_en = (wr && blocked > 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wen_cnt = 0;
    while (!resp_valid && lat < 40) begin
      if (jtag_wen) begin
        wen_cnt++;
        core_w_en = (wen_cnt <= blocked);
      end else begin
        core_w_en = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    core_w_en = 1'b0;
    chk("resp_arrived", 32'(resp_valid), 32'd1);
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("wen_cycles", 32'(wen_cnt), 32'(exp_wen));
    got_rdata = resp_rdata;
    got_err   = resp_err;

    repeat (hold) begin @(posedge clk); #1; end
    chk("resp_held", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_valid = 1'b0;
    chk("resp_dropped", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_wen"}, 32'(jtag_wen), 32'd0);
    chk({tag, "_addr"}, 32'(jtag_addr), 32'd0);
    chk({tag, "_wdata"}, jtag_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = init_val(i);

    #12;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_ready_release", 32'(req_ready), 32'd1);

    // Read x2
    do_cmd(1'b0, 5'd2, 32'h0, 0, 0);
    chk("x2_literal", got_rdata, 32'h0000_1000);
    chk("x2_err_literal", 32'(got_err), 32'd0);

    // Write x5, core idle, then read it back
    do_cmd(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 0);
    chk("x5_wr_err", 32'(got_err), 32'd0);
    do_cmd(1'b0, 5'd5, 32'h0, 0, 0);
    chk("x5_literal", got_rdata, 32'hDEAD_BEEF);

    // Write x7 blocked 3 cycles
    do_cmd(1'b1, 5'd7, 32'h1234_5678, 3, 0);
    chk("x7_wr_err", 32'(got_err), 32'd0);
    do_cmd(1'b0, 5'd7, 32'h0, 0, 0);
    chk("x7_literal", got_rdata, 32'h1234_5678);

    // Write x9 with core port stuck busy
    do_cmd(1'b1, 5'd9, 32'hAAAA_5555, 16, 0);
    chk("x9_wr_err_literal", 32'(got_err), 32'd1);
    do_cmd(1'b0, 5'd9, 32'h0, 0, 0);
    chk("x9_unchanged", got_rdata, 32'hA5A5_0009);

    // Last retry slot: 15 blocks then lands
    do_cmd(1'b1, 5'd10, 32'h0F0F_F0F0, 15, 0);
    chk("x10_wr_err", 32'(got_err), 32'd0);
    do_cmd(1'b0, 5'd10, 32'h0, 0, 0);
    chk("x10_literal", got_rdata, 32'h0F0F_F0F0);

    // x0 write is ignored and x0 reads zero
    do_cmd(1'b1, 5'd0, 32'hFFFF_FFFF, 0, 0);
    chk("x0_wr_err", 32'(got_err), 32'd0);
    do_cmd(1'b0, 5'd0, 32'h0, 0, 0);
    chk("x0_literal", got_rdata, 32'h0);

    // Response held for 5 cycles
    do_cmd(1'b0, 5'd31, 32'h0, 0, 5);
    do_cmd(1'b1, 5'd31, 32'hCAFE_F00D, 1, 5);
    chk("x31_literal", got_rdata, 32'hCAFE_F00D);

    // Reset in the middle of a blocked write to x12
    exp_valid = 1'b0;
    exp_addr = 5'd12;
    exp_wdata = 32'h5555_AAAA;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd12; req_wdata = 32'h5555_AAAA;
    core_w_en = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wen", 32'(jtag_wen), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk("mid_rst_ready_held", 32'(req_ready), 32'd0);
    core_w_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_release", 32'(req_ready), 32'd1);
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    chk("mid_rst_no_wen", 32'(jtag_wen), 32'd0);
    do_cmd(1'b0, 5'd12, 32'h0, 0, 0);
    chk("x12_unchanged", got_rdata, 32'hA5A5_000C);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_reg_ctrl.md
JTAG_REG_CTRL -- requirements
Module: jtag_reg_ctrl

Interface
REQ-001 SHALL provide these ports (name  direction  width  meaning):
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  debug command valid.
- req_ready_o  out  1  command accepted when high with req_valid_i.
- req_write_i  in  1  1 = register write, 0 = register read.
- req_addr_i  in  5  GPR index.
- req_wdata_i  in  32  write data.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_rdata_o  out  32  read data.
- resp_err_o  out  1  command failed.
- core_w_enable_i  in  1  write-back port enable of the register file, monitored.
- jtag_w_enable_o  out  1  debug write enable to the register file.
- jtag_addr_o  out  5  debug address to the register file.
- jtag_w_data_o  out  32  debug write data.
- jtag_r_data_i  in  32  debug read data from the register file, combinational on jtag_addr_o.

REQ-002 SHALL use a single clock clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, WRITE, READ, VERIFY, RESP.
REQ-004 IDLE: req_ready_o=1; on req_valid_i the block SHALL latch write, addr and wdata, then go to WRITE if write, else READ.
REQ-005 req_ready_o SHALL be 0 in every state other than IDLE.
REQ-006 A write to address 0 SHALL go directly to RESP with err=0, and jtag_w_enable_o SHALL never assert.
REQ-007 WRITE: jtag_w_enable_o=1 with the latched address and data. If core_w_enable_i=0 that cycle, the write has landed: go to VERIFY (macro on) or RESP (macro off).
REQ-008 WRITE with core_w_enable_i=1 (the core port has priority): increment the 4-bit retry counter and stay in WRITE.
REQ-009 After 16 consecutive blocked cycles: go to RESP with err=1 and leave the register unchanged.
REQ-010 READ: drive jtag_addr_o for one cycle, capture jtag_r_data_i into resp_rdata_o at the clock edge, then go to RESP with err=0 (total latency 2 cycles from acceptance to resp_valid_o).
REQ-011 A read of address 0 SHALL return 0x00000000.
REQ-012 RESP: resp_valid_o=1, and resp_rdata_o/resp_err_o SHALL hold stable until resp_ready_i=1.
REQ-013 On resp_ready_i=1 in RESP: return to IDLE and clear the retry counter. A new command is accepted no earlier than the following cycle.
REQ-014 jtag_w_enable_o SHALL be 0 in all states except WRITE.
REQ-015 jtag_addr_o SHALL hold the latched address from acceptance through RESP.
REQ-016 resp_rdata_o for a write SHALL be the written data (macro off) or the read-back data (macro on).

Reset
REQ-017 On rst_n=0, at any time including mid-command, the block SHALL go to IDLE and drop the pending command with no response. The following outputs SHALL take these values:
- req_ready_o=0 while reset is asserted, 1 after release.
- resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
- jtag_w_enable_o=0, jtag_addr_o=0, jtag_w_data_o=0.
- retry counter=0.

Configuration
REQ-018 Macro JTAG_WRITE_VERIFY_EN, when defined: VERIFY SHALL read back jtag_r_data_i one cycle after the landed write, with jtag_w_enable_o=0, then go to RESP.
- err=1 if the read-back data differs from the latched data.
- Write latency grows by 1 cycle.
REQ-019 Without JTAG_WRITE_VERIFY_EN: the VERIFY state SHALL not exist, and the write response SHALL be issued with err=0 directly after the landed write.

Verification
REQ-020 Read x2 after reset (regfile value 0x0000_1000) -> resp_valid_o 2 cycles after acceptance; rdata=0x00001000, err=0.
REQ-021 Write x5=0xDEADBEEF with core idle -> one cycle of jtag_w_enable_o=1, addr=5; response err=0; subsequent read of x5 returns 0xDEADBEEF.
REQ-022 Write x7=0x12345678 with core_w_enable_i=1 for 3 cycles -> jtag_w_enable_o held 4 cycles; write lands on the 4th; err=0.
REQ-023 Write x9 with core_w_enable_i stuck at 1 -> after 16 blocked cycles err=1; x9 unchanged.
REQ-024 Write x0=0xFFFFFFFF -> jtag_w_enable_o never asserted; err=0; read x0 returns 0.
REQ-025 rst_n pulsed low during WRITE; separately, resp_ready_i held low for 5 cycles in RESP -> reset: all outputs at reset values, then IDLE with req_ready_o=1; held RESP: response fields stable for all 5 cycles.
